gate_bist: RTL and testbench
============================

GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 SHALL provide parameter N_IN, default 11, stimulus width (2..32).
REQ-002 SHALL provide parameter N_OUT, default 10, response width (1..SIG_W).
REQ-003 SHALL provide parameter N_PAT, default 2048, patterns per run (2..2^20).
REQ-004 SHALL provide parameter SIG_W, default 16, signature register width.
REQ-005 SHALL provide parameter LFSR_POLY, default 11'h500, Galois stimulus mask (N_IN bits).
REQ-006 SHALL provide parameter LFSR_SEED, default 1, stimulus seed (nonzero, N_IN bits).
REQ-007 SHALL provide parameter MISR_POLY, default 16'hB400, Galois signature mask (SIG_W bits).
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 start_i  input  1  begin run; sampled in IDLE or DONE.
REQ-011 abort_i  input  1  synchronous abort of a run.
REQ-012 resp_i  input  N_OUT  response of the combinational gate model under test.
REQ-013 stim_o  output  N_IN  stimulus vector to the gate model.
REQ-014 busy_o  output  1  high in RUN.
REQ-015 done_o  output  1  high in DONE.
REQ-016 sig_o  output  SIG_W  signature register contents.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE.
REQ-018 IDLE/DONE with start_i=1 SHALL go to RUN, load lfsr=LFSR_SEED, sig=0, cnt=0 at the same edge.
REQ-019 stim_o SHALL equal lfsr at all times; resp_i is sampled in the same cycle stim_o is presented (zero-latency DUT).
REQ-020 Each RUN cycle: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0).
REQ-021 Each RUN cycle: sig <= (sig>>1) ^ (sig[0] ? MISR_POLY : 0) ^ zero_ext(resp_i).
REQ-022 cnt SHALL increment per RUN cycle; at edge with cnt==N_PAT-1, go to DONE; exactly N_PAT patterns compacted, busy_o high exactly N_PAT cycles.
REQ-023 DONE SHALL hold sig_o, stim_o stable until next start_i.
REQ-024 abort_i in RUN SHALL go to IDLE at next edge, sig cleared, no done_o pulse; abort_i has priority over the final-pattern transition.
REQ-025 abort_i in IDLE/DONE SHALL be ignored; start_i in RUN SHALL be ignored.
REQ-026 Simultaneous start_i and abort_i in DONE: start wins (abort ignored outside RUN).

Reset
REQ-027 rst_n=0 SHALL force IDLE immediately: lfsr=LFSR_SEED, sig=0, cnt=0, busy_o=0, done_o=0, pass_o=0.
REQ-028 Reset mid-run SHALL discard the run; no partial signature retained.

Configuration
REQ-029 Macro GATE_BIST_CMP_EN: when defined, add input golden_i (SIG_W) and output pass_o (1); pass_o = done_o & (sig==golden_i), registered at DONE entry, cleared on leaving DONE.
REQ-030 Without GATE_BIST_CMP_EN: golden_i and pass_o SHALL not exist; all other behaviour identical.

Verification
REQ-031 N_IN=4, LFSR_POLY=4'hC, seed 1, N_PAT=4, start -> stim_o sequence 1,C,6,3; busy_o 4 cycles; done_o next cycle.
REQ-032 Same config, N_OUT=4, resp_i=stim_o loopback, SIG_W=16, MISR_POLY=16'hB400 -> sig_o=16'h2D03 in DONE.
REQ-033 Same run with resp_i tied 0 -> sig_o=16'h0000; with CMP_EN and golden_i=16'h2D03 on loopback -> pass_o=1; golden_i=16'h2D02 -> pass_o=0.
REQ-034 abort_i at pattern 2 of 4 -> IDLE next edge, done_o never asserted, sig_o=0; subsequent start reproduces REQ-032.
REQ-035 rst_n low mid-run at pattern 3 -> outputs at reset values without waiting for clk; start after release repeats REQ-031 sequence.
REQ-036 Default params, start in DONE -> run restarts from seed 1, sig cleared, 2048 busy cycles.

Source files
------------

// File: rtl/gate_bist.sv
// gate_bist: self-contained logic BIST controller for a combinational gate model.
//
// A Galois LFSR drives the stimulus vector; the response of the gate model is
// folded into a Galois MISR for exactly N_PAT patterns, after which the
// signature is held in DONE until the next start.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start_i    in   1      begin a run (honoured in IDLE or DONE)
//   abort_i    in   1      synchronous abort (honoured in RUN only)
//   resp_i     in   N_OUT  response of the gate model to stim_o (same cycle)
//   golden_i   in   SIG_W  expected signature      (GATE_BIST_CMP_EN only)
//   stim_o     out  N_IN   stimulus vector (always equals the LFSR)
//   busy_o     out  1      high in RUN
//   done_o     out  1      high in DONE
//   sig_o      out  SIG_W  signature register
//   pass_o     out  1      signature matched golden_i (GATE_BIST_CMP_EN only)
//   state_o    out  2      FSM state for debug/checkers (0 IDLE, 1 RUN, 2 DONE)
//
// Configuration
//   GATE_BIST_CMP_EN  when defined, adds golden_i/pass_o and the on-chip
//                     signature comparison.
//
// Handshake: start_i and abort_i are level-sampled on each rising edge; there
// is no ready. start_i is ignored in RUN, abort_i is ignored outside RUN, and
// in RUN abort_i beats the final-pattern transition.
module gate_bist #(
    parameter int               N_IN      = 11,
    parameter int               N_OUT     = 10,
    parameter int               N_PAT     = 2048,
    parameter int               SIG_W     = 16,
    parameter logic [N_IN-1:0]  LFSR_POLY = 11'h500,
    parameter logic [N_IN-1:0]  LFSR_SEED = {{(N_IN-1){1'b0}}, 1'b1},
    parameter logic [SIG_W-1:0] MISR_POLY = 16'hB400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [N_OUT-1:0] resp_i,
`ifdef GATE_BIST_CMP_EN
    input  logic [SIG_W-1:0] golden_i,
    output logic             pass_o,
`endif
    output logic [N_IN-1:0]  stim_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [SIG_W-1:0] sig_o,
    output logic [1:0]       state_o
);

    localparam int CNT_W = (N_PAT > 2) ? $clog2(N_PAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   lfsr_q, lfsr_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIG_W-1:0]  resp_ext;

    assign resp_ext = SIG_W'(resp_i);

`ifdef GATE_BIST_CMP_EN
    logic pass_q, pass_d;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
`ifdef GATE_BIST_CMP_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RUN;
                    lfsr_d  = LFSR_SEED;
                    sig_d   = '0;
                    cnt_d   = '0;
`ifdef GATE_BIST_CMP_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            RUN: begin
                if (abort_i) begin
                    // Aborted runs leave nothing behind: counters and signature
                    // return to their idle values.
                    state_d = IDLE;
                    lfsr_d  = LFSR_SEED;
                    sig_d   = '0;
                    cnt_d   = '0;
                end else begin
                    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
                    sig_d  = (sig_q >> 1) ^ (sig_q[0] ? MISR_POLY : '0) ^ resp_ext;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        cnt_d   = '0;
`ifdef GATE_BIST_CMP_EN
                        // Compare the final signature as it is written.
                        pass_d  = (sig_d == golden_i);
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lfsr_d  = LFSR_SEED;
                sig_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            sig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef GATE_BIST_CMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign pass_o = pass_q;
`endif

    assign stim_o  = lfsr_q;
    assign sig_o   = sig_q;
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign state_o = state_q;

endmodule

// File: tb/tb_gate_bist.sv
module tb_gate_bist;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT A: small verification config ----------------
  logic        start_a = 1'b0;
  logic        abort_a = 1'b0;
  logic [3:0]  resp_a;
  logic [3:0]  stim_a;
  logic        busy_a, done_a;
  logic [15:0] sig_a;
  logic [1:0]  state_a;
  int          mode_a = 0;   // 0 loopback, 1 tied zero, 2 stim ^ 5

  assign resp_a = (mode_a == 0) ? stim_a : (mode_a == 1) ? 4'h0 : (stim_a ^ 4'h5);

`ifdef GATE_BIST_CMP_EN
  logic [15:0] golden_a = 16'h2D03;
  logic        pass_a;
`endif

  gate_bist #(
    .N_IN(4), .N_OUT(4), .N_PAT(4), .SIG_W(16),
    .LFSR_POLY(4'hC), .LFSR_SEED(4'h1), .MISR_POLY(16'hB400)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .resp_i(resp_a),
`ifdef GATE_BIST_CMP_EN
    .golden_i(golden_a), .pass_o(pass_a),
`endif
    .stim_o(stim_a), .busy_o(busy_a), .done_o(done_a), .sig_o(sig_a),
    .state_o(state_a)
  );

  // ---------------- DUT B: default parameters ----------------
  logic        start_b = 1'b0;
  logic        abort_b = 1'b0;
  logic [9:0]  resp_b;
  logic [10:0] stim_b;
  logic        busy_b, done_b;
  logic [15:0] sig_b;
  logic [1:0]  state_b;

  assign resp_b = stim_b[10:1];

`ifdef GATE_BIST_CMP_EN
  logic [15:0] golden_b = 16'h0000;
  logic        pass_b;
`endif

  gate_bist u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .resp_i(resp_b),
`ifdef GATE_BIST_CMP_EN
    .golden_i(golden_b), .pass_o(pass_b),
`endif
    .stim_o(stim_b), .busy_o(busy_b), .done_o(done_b), .sig_o(sig_b),
    .state_o(state_b)
  );

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th pattern of a run: the seed advanced k times by the Galois rule.
  function automatic logic [31:0] lfsr_at(input logic [31:0] poly, input int k);
    logic [31:0] v;
    v = 32'd1;
    for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? poly : 32'd0);
    return v;
  endfunction

  function automatic logic [15:0] misr_fold(input logic [15:0] s, input logic [15:0] r);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000) ^ r;
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 run, 2 done; idx = patterns compacted so far this run.
  int          ma_phase, ma_idx, mb_phase, mb_idx;
  logic [15:0] ma_sig, mb_sig;
  logic        ma_pass, mb_pass;
  logic [31:0] ma_s, mb_s;
  logic [15:0] ma_r, mb_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_phase = 0; ma_idx = 0; ma_sig = 16'h0; ma_pass = 1'b0;
    end else if (ma_phase == 1) begin
      if (abort_a) begin
        ma_phase = 0; ma_idx = 0; ma_sig = 16'h0;
      end else begin
        ma_s = lfsr_at(32'hC, ma_idx);
        ma_r = (mode_a == 0) ? {12'h0, ma_s[3:0]} :
               (mode_a == 1) ? 16'h0 : {12'h0, ma_s[3:0] ^ 4'h5};
        ma_sig = misr_fold(ma_sig, ma_r);
        ma_idx++;
        if (ma_idx == 4) begin
          ma_phase = 2;
`ifdef GATE_BIST_CMP_EN
          ma_pass = (ma_sig == golden_a);
`endif
        end
      end
    end else if (start_a) begin
      ma_phase = 1; ma_idx = 0; ma_sig = 16'h0; ma_pass = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_phase = 0; mb_idx = 0; mb_sig = 16'h0; mb_pass = 1'b0;
    end else if (mb_phase == 1) begin
      if (abort_b) begin
        mb_phase = 0; mb_idx = 0; mb_sig = 16'h0;
      end else begin
        mb_s = lfsr_at(32'h500, mb_idx);
        mb_r = {6'h0, mb_s[10:1]};
        mb_sig = misr_fold(mb_sig, mb_r);
        mb_idx++;
        if (mb_idx == 2048) begin
          mb_phase = 2;
`ifdef GATE_BIST_CMP_EN
          mb_pass = (mb_sig == golden_b);
`endif
        end
      end
    end else if (start_b) begin
      mb_phase = 1; mb_idx = 0; mb_sig = 16'h0; mb_pass = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_busy", {31'h0, busy_a}, {31'h0, ma_phase == 1});
      chk("a_done", {31'h0, done_a}, {31'h0, ma_phase == 2});
      chk("a_sig", {16'h0, sig_a}, {16'h0, ma_sig});
      if (ma_phase != 0) chk("a_stim", {28'h0, stim_a}, lfsr_at(32'hC, ma_idx));
      chk("b_busy", {31'h0, busy_b}, {31'h0, mb_phase == 1});
      chk("b_done", {31'h0, done_b}, {31'h0, mb_phase == 2});
      chk("b_sig", {16'h0, sig_b}, {16'h0, mb_sig});
      if (mb_phase != 0) chk("b_stim", {21'h0, stim_b}, lfsr_at(32'h500, mb_idx));
`ifdef GATE_BIST_CMP_EN
      chk("a_pass", {31'h0, pass_a}, {31'h0, ma_pass});
      chk("b_pass", {31'h0, pass_b}, {31'h0, mb_pass});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  logic [3:0] seq_a [4] = '{4'h1, 4'hC, 4'h6, 4'h3};

  // Full run on DUT A; start is held one extra cycle into RUN (must be ignored).
  task automatic run_a(input int mode, input logic [15:0] exp_sig, input logic with_abort);
    @(negedge clk);
    mode_a = mode;
    start_a = 1'b1;
    abort_a = with_abort;
    @(negedge clk);
    abort_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("a_seq_stim", {28'h0, stim_a}, {28'h0, seq_a[i]});
      chk("a_seq_busy", {31'h0, busy_a}, 32'h1);
      if (i == 1) start_a = 1'b0;
      @(negedge clk);
    end
    chk("a_run_done", {31'h0, done_a}, 32'h1);
    chk("a_run_sig", {16'h0, sig_a}, {16'h0, exp_sig});
  endtask

  task automatic run_b;
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_first_stim", {21'h0, stim_b}, 32'h1);
    chk("b_first_sig", {16'h0, sig_b}, 32'h0);
    for (int i = 0; i < 3000 && !done_b; i++) begin
      if (busy_b) busy_cnt++;
      @(negedge clk);
    end
    chk("b_done_reached", {31'h0, done_b}, 32'h1);
    chk("b_busy_cycles", busy_cnt, 32'd2048);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_done", {31'h0, done_a}, 32'h0);
    chk("rst_sig", {16'h0, sig_a}, 32'h0);
    chk("rst_stim", {28'h0, stim_a}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback run: 1,C,6,3 then signature 2D03.
    run_a(0, 16'h2D03, 1'b0);
`ifdef GATE_BIST_CMP_EN
    chk("a_pass_match", {31'h0, pass_a}, 32'h1);
`endif
    // Abort while in DONE is ignored.
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("a_done_abort_ignored", {31'h0, done_a}, 32'h1);
    chk("a_done_sig_hold", {16'h0, sig_a}, 32'h2D03);

    // Restart from DONE with start and abort together: start wins.
`ifdef GATE_BIST_CMP_EN
    golden_a = 16'h2D02;
`endif
    run_a(0, 16'h2D03, 1'b1);
`ifdef GATE_BIST_CMP_EN
    chk("a_pass_mismatch", {31'h0, pass_a}, 32'h0);
    golden_a = 16'h2D03;
`endif

    // Response tied to zero, then stim ^ 5.
    run_a(1, 16'h0000, 1'b0);
    run_a(2, 16'h5A05, 1'b0);

    // Abort at pattern 2.
    @(negedge clk);
    mode_a = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_abort_at_p2", {28'h0, stim_a}, 32'h6);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("a_abort_busy", {31'h0, busy_a}, 32'h0);
    chk("a_abort_done", {31'h0, done_a}, 32'h0);
    chk("a_abort_sig", {16'h0, sig_a}, 32'h0);
    repeat (6) @(negedge clk);
    run_a(0, 16'h2D03, 1'b0);

    // Asynchronous reset at pattern 3.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_rst_at_p3", {28'h0, stim_a}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_busy", {31'h0, busy_a}, 32'h0);
    chk("a_async_done", {31'h0, done_a}, 32'h0);
    chk("a_async_sig", {16'h0, sig_a}, 32'h0);
    chk("a_async_stim", {28'h0, stim_a}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_a(0, 16'h2D03, 1'b0);

    // Default configuration: full run, then restart from DONE.
    run_b();
    run_b();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
